// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that shares one Booth multiplier between NREQ requesters.
// Define MUL_ARB_TIMEOUT_EN to enable the WAIT-state timeout and the sticky err flag.
module mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_prod,
    output logic                  busy,
    output logic                  err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d, last_q, last_d, sel, j;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] rsp_q, rsp_d;
    logic               err_q, err_d, tmo;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    assign tmo   = cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
`else
    assign tmo = 1'b0;
`endif

    // Descending scan so the nearest requester after last is the final write.
    always_comb begin
        sel = last_q;
        j   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IW'((int'(last_q) + k) % NREQ);
            if (req[j]) sel = j;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = LAUNCH;
                idx_d   = sel;
                a_d     = a_in[sel*WIDTH +: WIDTH];
                b_d     = b_in[sel*WIDTH +: WIDTH];
            end
            LAUNCH: state_d = WAIT;
            WAIT: if (mul_done || tmo) begin
                state_d = RESP;
                last_d  = idx_q;
                rsp_d   = mul_done ? mul_prod : '0;
                err_d   = err_q | ~mul_done;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    assign gnt       = (state_q == IDLE) ? '0 : NREQ'(1) << idx_q;
    assign rsp_valid = (state_q == RESP) ? NREQ'(1) << idx_q : '0;
    assign mul_start = state_q == LAUNCH;
    assign busy      = state_q != IDLE;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign rsp_data  = rsp_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed vectors and corner-case sequences for mul_arbiter (WIDTH=8, NREQ=4, TIMEOUT=16).
module tb_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [3:0]  gnt, rsp_valid;
    logic [15:0] rsp_data, mul_prod = 16'hDEAD;
    logic        mul_start, mul_done = 1'b0, busy, err;
    logic [7:0]  mul_a, mul_b;
    int          n_tests = 0, n_fail = 0;

    mul_arbiter #(.WIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_prod(mul_prod), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_first;
        logic [3:0]  req;
        logic [7:0]  a, b;
        int          lat;
        int          idx;
        logic [15:0] prod;
    } vec_t;
    vec_t tv[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    // Served slice gets the operands; all other slices carry a distinct filler.
    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        a_in = {4{8'h77}};
        b_in = {4{8'h77}};
        a_in[idx*8 +: 8] = a;
        b_in[idx*8 +: 8] = b;
    endtask

    // Runs one service from IDLE; operands are scrambled after the latch point and req set to post_req.
    task automatic do_service(input int lat, input int idx, input logic [15:0] prod,
                              input logic [3:0] post_req, input string nm);
        logic [31:0] sa, sb;
        logic signed [15:0] p;
        tick();
        check({nm, " gnt"}, 32'(gnt), 32'(4'b1 << idx));
        check({nm, " start"}, 32'(mul_start), 32'd1);
        sa = a_in;
        sb = b_in;
        a_in = ~a_in;
        b_in = ~b_in;
        req = post_req;
        tick();
        check({nm, " start_low"}, 32'(mul_start), 32'd0);
        repeat (lat - 1) tick();
        check({nm, " no_early_rsp"}, 32'(rsp_valid), 32'd0);
        p = $signed(mul_a) * $signed(mul_b);
        mul_prod = p;
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        mul_prod = 16'hDEAD;
        check({nm, " rsp_valid"}, 32'(rsp_valid), 32'(4'b1 << idx));
        check({nm, " rsp_data"}, 32'(rsp_data), 32'(prod));
        check({nm, " gnt_resp"}, 32'(gnt), 32'(4'b1 << idx));
        a_in = sa;
        b_in = sb;
        tick();
        check({nm, " idle_busy"}, 32'(busy), 32'd0);
        check({nm, " idle_rsp"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        tv[0] = '{1'b0, 4'b0001, 8'd3,   8'hFB, 10, 0, 16'hFFF1};
        tv[1] = '{1'b1, 4'b1111, 8'd7,   8'd9,  2,  0, 16'h003F};
        tv[2] = '{1'b0, 4'b1111, 8'hFF,  8'hFF, 3,  1, 16'h0001};
        tv[3] = '{1'b0, 4'b1111, 8'h80,  8'h80, 1,  2, 16'h4000};
        tv[4] = '{1'b0, 4'b1111, 8'h7F,  8'h80, 4,  3, 16'hC080};
        tv[5] = '{1'b0, 4'b1111, 8'd0,   8'd55, 2,  0, 16'h0000};
        tv[6] = '{1'b0, 4'b0100, 8'd12,  8'hFD, 1,  2, 16'hFFDC};
        tv[7] = '{1'b0, 4'b0100, 8'hF9,  8'd6,  3,  2, 16'hFFD6};

        do_reset();
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst start", 32'(mul_start), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst ops", {mul_a, mul_b, rsp_data}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (tv[i].rst_first) do_reset();
            req = tv[i].req;
            set_ops(tv[i].idx, tv[i].a, tv[i].b);
            do_service(tv[i].lat, tv[i].idx, tv[i].prod, tv[i].req, $sformatf("v%0d", i));
        end

        // Fairness: 1 arrives while 2 is served, so 1 goes before 2 again; last service drops req mid-flight.
        do_reset();
        req = 4'b0100;
        a_in = {8'h77, 8'd2, 8'd4, 8'h77};
        b_in = {8'h77, 8'd3, 8'd5, 8'h77};
        do_service(2, 2, 16'h0006, 4'b0110, "fair2a");
        do_service(2, 1, 16'h0014, 4'b0110, "fair1");
        do_service(2, 2, 16'h0006, 4'b0000, "fair2b");

        // Spurious mul_done in IDLE.
        mul_prod = 16'h1234;
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        check("spur busy", 32'(busy), 32'd0);
        check("spur rsp_valid", 32'(rsp_valid), 32'd0);
        check("spur rsp_data", 32'(rsp_data), 32'h0006);
        tick();
        check("spur rsp_valid2", 32'(rsp_valid), 32'd0);

        // No mul_done: timeout build responds after 16 WAIT cycles, default build waits forever.
        req = 4'b0001;
        set_ops(0, 8'd1, 8'd1);
        tick();
        tick();
        req = '0;
        repeat (15) tick();
        check("tmo busy15", 32'(busy), 32'd1);
        check("tmo rsp15", 32'(rsp_valid), 32'd0);
        tick();
`ifdef MUL_ARB_TIMEOUT_EN
        check("tmo rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo rsp_data", 32'(rsp_data), 32'd0);
        check("tmo err", 32'(err), 32'd1);
        repeat (3) tick();
        check("tmo err sticky", 32'(err), 32'd1);
        check("tmo idle", 32'(busy), 32'd0);
`else
        check("notmo rsp", 32'(rsp_valid), 32'd0);
        check("notmo busy", 32'(busy), 32'd1);
        repeat (40) tick();
        check("notmo busy2", 32'(busy), 32'd1);
        check("notmo err", 32'(err), 32'd0);
`endif
        do_reset();
        check("tmo err cleared", 32'(err), 32'd0);

        // Reset mid-WAIT, then a late mul_done from the abandoned operation.
        req = 4'b0001;
        set_ops(0, 8'd5, 8'd5);
        tick();
        tick();
        tick();
        check("rw in wait", 32'(busy), 32'd1);
        do_reset();
        check("rw busy", 32'(busy), 32'd0);
        check("rw gnt", 32'(gnt), 32'd0);
        check("rw mul_a", 32'(mul_a), 32'd0);
        mul_prod = 16'h1234;
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        check("rw late rsp", 32'(rsp_valid), 32'd0);
        check("rw late busy", 32'(busy), 32'd0);
        check("rw late data", 32'(rsp_data), 32'd0);
        tick();
        check("rw late rsp2", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
